// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one framebuffer RAM port between a scan-out prefetch FIFO and draw writes.
// Optional FB_ARB_STATS_EN adds saturating underflow and draw-stall counters.
module fb_arbiter #(
  parameter int ADDRW      = 17,
  parameter int DATAW      = 4,
  parameter int FB_PIXELS  = 76800,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 3,
  parameter int MAX_WAIT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_pop,
  output logic [DATAW-1:0] pix_data,
  output logic             underflow,
  input  logic             draw_valid,
  input  logic [ADDRW-1:0] draw_addr,
  input  logic [DATAW-1:0] draw_data,
  output logic             draw_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]      stat_underflows,
  output logic [15:0]      stat_stall_cycles
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(FB_PIXELS - 1);
  typedef enum logic [1:0] {WAIT_FRAME, FILL, RUN} state_t;
  state_t state, state_nx;
  logic [DATAW-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, level;
  logic [ADDRW-1:0] rd_addr;
  logic [WW-1:0] wait_cnt;
  logic inflight, do_read, do_write, pop, push, empty;
  always_comb begin
    level = count + CW'(inflight);
    state_nx = state;
    do_read = 1'b0;
    do_write = 1'b0;
    if (frame_start) state_nx = FILL;
    else if (state == FILL) begin
      do_read = level < CW'(FIFO_DEPTH);
      state_nx = (count == CW'(FIFO_DEPTH)) ? RUN : FILL;
    end else if (state == RUN) begin
      do_write = level >= CW'(LOW_WM) && ((draw_valid && wait_cnt >= WW'(MAX_WAIT)) || draw_valid);
      do_read = level < CW'(LOW_WM) || (!draw_valid && level < CW'(FIFO_DEPTH));
    end
  end
  assign empty      = count == '0;
  assign pop        = pix_pop && !empty && !frame_start;
  assign push       = inflight && !frame_start;
  assign pix_data   = empty ? '0 : fifo[rd_ptr];
  assign draw_ready = do_write;
  assign mem_en     = do_read || do_write;
  assign mem_we     = do_write;
  assign mem_addr   = do_write ? draw_addr : (do_read ? rd_addr : '0);
  assign mem_wdata  = do_write ? draw_data : '0;
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= mem_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_FRAME;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      inflight <= 1'b0;
      rd_addr <= '0;
      underflow <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= (draw_valid && do_write) ? '0 :
                  (draw_valid && wait_cnt < WW'(MAX_WAIT)) ? wait_cnt + WW'(1) : wait_cnt;
      if (frame_start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        inflight <= 1'b0;
        rd_addr <= '0;
        underflow <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr + PW'(pop);
        count <= count + CW'(push) - CW'(pop);
        inflight <= do_read;
        if (do_read) rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + ADDRW'(1);
        if (pix_pop && empty) underflow <= 1'b1;
      end
    end
  end
`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_underflows <= '0;
      stat_stall_cycles <= '0;
    end else if (frame_start) begin
      stat_underflows <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (pix_pop && empty && stat_underflows != '1) stat_underflows <= stat_underflows + 16'd1;
      if (draw_valid && !do_write && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized and directed checks of fb_arbiter against a queue-based model.
// A reduced FB_PIXELS keeps the read-address wrap reachable in a short run.
module tb_fb_arbiter;
  localparam int ADDRW = 17;
  localparam int FBP = 300;
  localparam int DEPTH = 8;
  localparam int LOW = 3;
  logic clk = 0, rst_n = 0, frame_start = 0, pix_pop = 0, draw_valid = 0;
  logic [ADDRW-1:0] draw_addr = 0;
  logic [3:0] draw_data = 0, mem_rdata = 0;
  logic [3:0] pix_data, mem_wdata;
  logic underflow, draw_ready, mem_en, mem_we;
  logic [ADDRW-1:0] mem_addr;
`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_underflows, stat_stall_cycles;
`endif
  fb_arbiter #(.FB_PIXELS(FBP)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .underflow(underflow), .draw_valid(draw_valid),
    .draw_addr(draw_addr), .draw_data(draw_data), .draw_ready(draw_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef FB_ARB_STATS_EN
    , .stat_underflows(stat_underflows), .stat_stall_cycles(stat_stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  logic [3:0] ram [0:(1<<ADDRW)-1];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  // model: a queue for the FIFO, one pending read, and a shadow copy of RAM
  logic [3:0] mram [0:(1<<ADDRW)-1];
  logic [3:0] q[$];
  logic [3:0] infl_d;
  bit infl, muf, wrap_seen;
  int mst, raddr, msu, mss, prev_rd;
  int tests = 0, fails = 0;
  logic s_en, s_we, s_uf, s_rdy;
  logic [ADDRW-1:0] s_addr;
  logic [3:0] s_pix;
  function automatic logic [3:0] f(int a);
    return 4'(a * 5 + 1);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit fs, input bit pop, input bit dv, input logic [ADDRW-1:0] da, input logic [3:0] dd);
    int occ, lvl;
    bit rd, wr;
    @(negedge clk);
    frame_start = fs; pix_pop = pop; draw_valid = dv; draw_addr = da; draw_data = dd;
    #1;
    occ = q.size();
    lvl = occ + int'(infl);
    rd = 0; wr = 0;
    if (!fs && mst == 1) rd = lvl < DEPTH;
    if (!fs && mst == 2) begin
      if (lvl < LOW) rd = 1;
      else if (dv) wr = 1;
      else rd = lvl < DEPTH;
    end
    chk("pix_data", pix_data, occ > 0 ? q[0] : 4'd0);
    chk("underflow", underflow, muf);
    chk("draw_ready", draw_ready, wr);
    chk("mem_en", mem_en, rd | wr);
    chk("mem_we", mem_we, wr);
    chk("mem_addr", mem_addr, wr ? da : (rd ? ADDRW'(raddr) : '0));
    chk("mem_wdata", mem_wdata, wr ? dd : 4'd0);
`ifdef FB_ARB_STATS_EN
    chk("stat_underflows", stat_underflows, msu);
    chk("stat_stall_cycles", stat_stall_cycles, mss);
`endif
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_pix = pix_data; s_uf = underflow; s_rdy = draw_ready;
    if (mem_en && !mem_we) begin
      if (prev_rd == FBP - 1) begin
        wrap_seen = 1;
        chk("wrap_addr", mem_addr, 0);
      end
      prev_rd = int'(mem_addr);
    end
    if (fs) begin
      q.delete(); infl = 0; raddr = 0; muf = 0; msu = 0; mss = 0; mst = 1;
    end else begin
      if (pop) begin
        if (occ > 0) void'(q.pop_front());
        else begin muf = 1; if (msu < 65535) msu++; end
      end
      if (infl) q.push_back(infl_d);
      if (wr) mram[da] = dd;
      infl = rd;
      if (rd) begin infl_d = mram[raddr]; raddr = (raddr + 1) % FBP; end
      if (dv && !wr && mss < 65535) mss++;
      if (mst == 1 && occ == DEPTH) mst = 2;
    end
  endtask
  initial begin
    int streak, max_streak, nw, k;
    bit found;
    for (int i = 0; i < (1 << ADDRW); i++) begin ram[i] = f(i); mram[i] = f(i); end
    mst = 0; raddr = 0; infl = 0; muf = 0; msu = 0; mss = 0; prev_rd = -1; wrap_seen = 0;
    draw_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pix_data", pix_data, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_draw_ready", draw_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("wait_pop_underflow", s_uf, 1);
    chk("wait_pop_pix", s_pix, 0);
`ifdef FB_ARB_STATS_EN
    chk("wait_pop_stat", stat_underflows, 1);
`endif
    cyc(1, 0, 0, 0, 0);
    chk("fs_no_access", s_en, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("fill_en", s_en, 1);
      chk("fill_addr", s_addr, i);
      chk("fill_underflow", s_uf, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("fill_done", s_en, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    k = 0;
    repeat (30) begin
      cyc(0, 1, 0, 0, 0);
      if (k < 4) chk("pix_seq", s_pix, f(k));
      k++;
    end
    chk("pop_run_underflow", s_uf, 0);
    streak = 0; max_streak = 0; nw = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(0, i[0], 1, 17'h100, 4'hA);
      if (s_rdy) begin nw++; streak = 0; end
      else begin streak++; if (streak > max_streak) max_streak = streak; end
    end
    cyc(0, 0, 0, 0, 0);
    chk("stall_bound", max_streak <= 4, 1);
    chk("writes_seen", nw > 0, 1);
    chk("write_landed", ram[17'h100], 4'hA);
    chk("draw_underflow", s_uf, 0);
    for (int i = 0; i < 400 && !wrap_seen; i++) cyc(0, 1, 0, 0, 0);
    chk("wrap_seen", wrap_seen, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 1, 0, 0, 0);
      found = s_en && !s_we;
    end
    chk("inflight_setup", found, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("flush_pix", s_pix, 0);
    chk("flush_underflow", s_uf, 0);
    chk("flush_read_en", s_en, 1);
    chk("flush_read_addr", s_addr, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
          ADDRW'($urandom_range(0, 511)), 4'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
